// File: rtl/psq_pkg.sv
// rtl/psq_pkg.sv - shared types and default constants for the sample queue
package psq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEQ  = 1'b1
    } psq_state_t;

    localparam int PSQ_DATA_W = 16;
    localparam int PSQ_DEPTH  = 1536;

endpackage

// File: rtl/dp_ram_param.sv
// rtl/dp_ram_param.sv - simple dual-port RAM, one write port, one registered read port
// Ports: clk; we/waddr/wdata write port; re/raddr read request; rdata registered read data.
// A read and write to the same address in one cycle returns the old contents.
module dp_ram_param
    import psq_pkg::*;
#(
    parameter int DATA_W = PSQ_DATA_W,
    parameter int DEPTH  = PSQ_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/param_sample_queue.sv
// rtl/param_sample_queue.sv - circular sample queue keeping the newest FULL_LVL samples, replays RD_LEN oldest-first
// Ports: clk, rst (async, active high), flush (sync clear);
//   auto_mode/start_seq select and request a replay; wrt_smpl/new_smpl write a sample;
//   smpl_out/smpl_vld/seq_done carry the replay; sequencing = reads being issued;
//   full/fill_cnt report occupancy.
module param_sample_queue
    import psq_pkg::*;
#(
    parameter int DATA_W   = PSQ_DATA_W,
    parameter int DEPTH    = PSQ_DEPTH,
    parameter int FULL_LVL = 1532,
    parameter int RD_LEN   = 1021,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              auto_mode,
    input  logic              start_seq,
    input  logic              wrt_smpl,
    input  logic [DATA_W-1:0] new_smpl,
    output logic [DATA_W-1:0] smpl_out,
    output logic              smpl_vld,
    output logic              sequencing,
    output logic              seq_done,
    output logic              full,
    output logic [CW-1:0]     fill_cnt
);

    if (FULL_LVL > DEPTH - 2) begin : g_bad_full_lvl
        $error("param_sample_queue: FULL_LVL must be <= DEPTH-2");
    end
    if (RD_LEN < 1 || RD_LEN > FULL_LVL) begin : g_bad_rd_len
        $error("param_sample_queue: RD_LEN must be in 1..FULL_LVL");
    end

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    psq_state_t    state, state_nxt;
    logic [AW-1:0] wr_ptr, old_ptr, old_ptr_nxt, rd_ptr, rd_ptr_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          trigger;
    logic          last_rd;
    logic          vld_q, done_q;

    assign full       = (fill_cnt == CW'(FULL_LVL));
    assign sequencing = (state == SEQ);
    assign smpl_vld   = vld_q;
    assign seq_done   = done_q;

    // Once full, every write pushes the oldest sample out of the window.
    assign old_ptr_nxt = (wrt_smpl && full) ? ptr_inc(old_ptr) : old_ptr;

    assign trigger = (state == IDLE) && full && (auto_mode ? wrt_smpl : start_seq);
    assign last_rd = (state == SEQ) && (cnt == CW'(RD_LEN - 1));

    always_comb begin
        state_nxt  = state;
        rd_ptr_nxt = rd_ptr;
        cnt_nxt    = cnt;
        case (state)
            IDLE: begin
                if (trigger) begin
                    // Start from the oldest sample as it stands after this cycle's write.
                    rd_ptr_nxt = old_ptr_nxt;
                    cnt_nxt    = '0;
                    state_nxt  = SEQ;
                end
            end
            SEQ: begin
                rd_ptr_nxt = ptr_inc(rd_ptr);
                cnt_nxt    = cnt + 1'b1;
                if (last_rd) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            old_ptr  <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            fill_cnt <= '0;
            vld_q    <= 1'b0;
            done_q   <= 1'b0;
        end else if (flush) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            old_ptr  <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            fill_cnt <= '0;
            vld_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            if (wrt_smpl) begin
                wr_ptr <= ptr_inc(wr_ptr);
                if (!full) begin
                    fill_cnt <= fill_cnt + 1'b1;
                end
            end
            old_ptr <= old_ptr_nxt;
            state   <= state_nxt;
            rd_ptr  <= rd_ptr_nxt;
            cnt     <= cnt_nxt;
            // Align valid/done with the RAM's one-cycle read latency.
            vld_q   <= (state == SEQ);
            done_q  <= last_rd;
        end
    end

    dp_ram_param #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wrt_smpl && !flush),
        .waddr (wr_ptr),
        .wdata (new_smpl),
        .re    (state == SEQ),
        .raddr (rd_ptr),
        .rdata (smpl_out)
    );

endmodule

// File: tb/tb_param_sample_queue.sv
// tb/tb_param_sample_queue.sv - directed self-checking bench for param_sample_queue
module tb_param_sample_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush, auto_mode, start_seq, wrt_smpl;
    logic [15:0] new_smpl, smpl_out;
    logic        smpl_vld, sequencing, seq_done, full;
    logic [4:0]  fill_cnt;

    logic        d_flush, d_auto, d_start, d_wrt;
    logic [15:0] d_new, d_out;
    logic        d_vld, d_seq, d_done, d_full;
    logic [10:0] d_fill;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    param_sample_queue #(
        .DATA_W(16), .DEPTH(16), .FULL_LVL(12), .RD_LEN(8)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .auto_mode(auto_mode),
        .start_seq(start_seq), .wrt_smpl(wrt_smpl), .new_smpl(new_smpl),
        .smpl_out(smpl_out), .smpl_vld(smpl_vld), .sequencing(sequencing),
        .seq_done(seq_done), .full(full), .fill_cnt(fill_cnt)
    );

    param_sample_queue dut_def (
        .clk(clk), .rst(rst), .flush(d_flush), .auto_mode(d_auto),
        .start_seq(d_start), .wrt_smpl(d_wrt), .new_smpl(d_new),
        .smpl_out(d_out), .smpl_vld(d_vld), .sequencing(d_seq),
        .seq_done(d_done), .full(d_full), .fill_cnt(d_fill)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Writes base..base+11 into an empty queue; no replay can start while filling.
    task automatic fill12(input logic [15:0] base);
        for (int i = 0; i < 12; i++) begin
            wrt_smpl = 1'b1;
            new_smpl = base + 16'(i);
            tick();
            chk("fill cnt", 32'(fill_cnt), 32'(i + 1));
            chk("fill no seq", 32'(sequencing), 32'd0);
        end
        wrt_smpl = 1'b0;
        chk("fill full", 32'(full), 32'd1);
    endtask

    // Called right after a trigger edge: expects 8 samples first..first+7, one done on the 8th.
    task automatic watch(input logic [15:0] first, input int poke, input string tag);
        int n  = 0;
        int dn = 0;
        for (int c = 0; c < 12; c++) begin
            start_seq = (c == poke);
            tick();
            if (seq_done) begin
                dn++;
                chk({tag, " done with last"}, 32'(n), 32'd7);
            end
            if (smpl_vld) begin
                chk({tag, " data"}, 32'(smpl_out), 32'(first + 16'(n)));
                n++;
            end
        end
        start_seq = 1'b0;
        chk({tag, " count"}, 32'(n), 32'd8);
        chk({tag, " dones"}, 32'(dn), 32'd1);
        chk({tag, " idle after"}, 32'(sequencing), 32'd0);
    endtask

    initial begin
        int k, dn, rises, bad, n;
        logic prev;
        int firsts [5];

        rst = 1'b1; flush = 1'b0; auto_mode = 1'b1; start_seq = 1'b0;
        wrt_smpl = 1'b0; new_smpl = '0;
        d_flush = 1'b0; d_auto = 1'b1; d_start = 1'b0; d_wrt = 1'b0; d_new = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("reset fill", 32'(fill_cnt), 32'd0);
        chk("reset full", 32'(full), 32'd0);
        chk("reset vld", 32'(smpl_vld), 32'd0);
        chk("reset seq", 32'(sequencing), 32'd0);
        chk("reset done", 32'(seq_done), 32'd0);

        // Fill with 0..11, then the 13th write starts an auto replay of 1..8.
        fill12(16'h0000);
        wrt_smpl = 1'b1; new_smpl = 16'h000C;
        tick();
        wrt_smpl = 1'b0;
        chk("auto trig seq", 32'(sequencing), 32'd1);
        chk("auto fill hold", 32'(fill_cnt), 32'd12);
        watch(16'h0001, -1, "auto");

        // 40 back-to-back writes 13..52: replays trigger every 9 cycles on writes 13,22,31,40,49.
        firsts = '{2, 11, 20, 29, 38};
        k = 0; dn = 0; rises = 0; prev = 1'b0;
        for (int c = 0; c < 50; c++) begin
            wrt_smpl = (c < 40);
            new_smpl = 16'(13 + c);
            tick();
            if (sequencing && !prev) rises++;
            prev = sequencing;
            if (seq_done) begin
                dn++;
                chk("wrap done pos", 32'(k % 8), 32'd7);
            end
            if (smpl_vld) begin
                if (k < 40) chk("wrap data", 32'(smpl_out), 32'(firsts[k / 8] + k % 8));
                k++;
            end
        end
        wrt_smpl = 1'b0;
        chk("wrap samples", 32'(k), 32'd40);
        chk("wrap dones", 32'(dn), 32'd5);
        chk("wrap triggers", 32'(rises), 32'd5);

        // Commanded mode: a write while full no longer triggers; start_seq does.
        auto_mode = 1'b0;
        wrt_smpl = 1'b1; new_smpl = 16'd53;
        tick();
        wrt_smpl = 1'b0;
        chk("cmd no write trig", 32'(sequencing), 32'd0);
        start_seq = 1'b1;
        tick();
        start_seq = 1'b0;
        chk("cmd trig", 32'(sequencing), 32'd1);
        watch(16'd42, 2, "cmd");

        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush fill", 32'(fill_cnt), 32'd0);
        chk("flush full", 32'(full), 32'd0);
        start_seq = 1'b1;
        tick();
        start_seq = 1'b0;
        chk("cmd not full ignored", 32'(sequencing), 32'd0);

        // Async reset on the third replayed sample.
        auto_mode = 1'b1;
        fill12(16'd100);
        wrt_smpl = 1'b1; new_smpl = 16'd112;
        tick();
        wrt_smpl = 1'b0;
        repeat (3) tick();
        chk("rst pre vld", 32'(smpl_vld), 32'd1);
        chk("rst pre data", 32'(smpl_out), 32'd103);
        #2 rst = 1'b1;
        #1;
        chk("rst vld", 32'(smpl_vld), 32'd0);
        chk("rst seq", 32'(sequencing), 32'd0);
        chk("rst done", 32'(seq_done), 32'd0);
        chk("rst full", 32'(full), 32'd0);
        chk("rst fill", 32'(fill_cnt), 32'd0);
        #2 rst = 1'b0;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (seq_done || smpl_vld) n++;
        end
        chk("rst no resume", 32'(n), 32'd0);

        // Synchronous flush on the third replayed sample.
        fill12(16'd100);
        wrt_smpl = 1'b1; new_smpl = 16'd112;
        tick();
        wrt_smpl = 1'b0;
        repeat (3) tick();
        chk("flush pre data", 32'(smpl_out), 32'd103);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush vld", 32'(smpl_vld), 32'd0);
        chk("flush seq", 32'(sequencing), 32'd0);
        chk("flush mid fill", 32'(fill_cnt), 32'd0);
        chk("flush mid full", 32'(full), 32'd0);
        n = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (seq_done || smpl_vld) n++;
        end
        chk("flush no resume", 32'(n), 32'd0);

        // Default parameters: 1600 writes of their index, one replay of 1..1021.
        n = 0; bad = 0; dn = 0; k = 0;
        for (int c = 0; c < 2700; c++) begin
            d_wrt = (c < 1600);
            d_new = 16'(c);
            tick();
            if (d_done) begin
                dn++;
                k = n + 1;
            end
            if (d_vld) begin
                if (d_out !== 16'(1 + n)) bad++;
                n++;
            end
        end
        d_wrt = 1'b0;
        chk("def samples", 32'(n), 32'd1021);
        chk("def data errs", 32'(bad), 32'd0);
        chk("def dones", 32'(dn), 32'd1);
        chk("def done pos", 32'(k), 32'd1021);
        chk("def fill", 32'(d_fill), 32'd1532);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
